// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit BHT plus tagged BTB for the RV32I pipeline.
// Fetch-side lookup is zero latency; EX-side resolve drives redirect and trains both tables.
module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        if_pred_taken,
  output logic [31:0] if_pred_target,
  input  logic        ex_valid,
  input  logic        ex_stall,
  input  logic        ex_is_branch,
  input  logic        ex_is_jal,
  input  logic [31:0] ex_pc,
  input  logic        ex_br_en,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [1:0]          bht_cnt [ENTRIES];
  logic [ENTRIES-1:0]  btb_vld;
  logic [TAG_BITS-1:0] btb_tag [ENTRIES];
  logic [31:0]         btb_tgt [ENTRIES];

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  logic [INDEX_BITS-1:0] if_idx;
  logic [INDEX_BITS-1:0] ex_idx;
  logic [TAG_BITS-1:0]   if_tag;
  logic [TAG_BITS-1:0]   ex_tag;
  logic [31:0]           if_seq_pc;
  logic [31:0]           ex_seq_pc;
  logic                  unused_pc_bits;

  assign if_idx         = if_pc[INDEX_BITS+1:2];
  assign if_tag         = if_pc[31:INDEX_BITS+2];
  assign ex_idx         = ex_pc[INDEX_BITS+1:2];
  assign ex_tag         = ex_pc[31:INDEX_BITS+2];
  assign if_seq_pc      = if_pc + 32'd4;
  assign ex_seq_pc      = ex_pc + 32'd4;
  assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

  // Fetch-side lookup: sees pre-update table state, no bypass from EX.
  logic if_hit;

  assign if_hit         = btb_vld[if_idx] & (btb_tag[if_idx] == if_tag);
  assign if_pred_taken  = if_hit & bht_cnt[if_idx][1];
  assign if_pred_target = if_pred_taken ? btb_tgt[if_idx] : if_seq_pc;

  // EX-side resolve; mispredict is reported even while stalled.
  logic        act;
  logic        taken;
  logic        train;
  logic [31:0] correct_pc;
  logic [1:0]  cnt_next;

  assign act        = ex_valid & ~rst & (ex_is_branch | ex_is_jal);
  assign taken      = ex_is_jal | ex_br_en;
  assign correct_pc = taken ? ex_target : ex_seq_pc;
  assign mispredict = act & ((taken != ex_pred_taken) | (ex_pred_target != correct_pc));
  assign redirect_pc = act ? correct_pc : ex_seq_pc;
  assign train      = act & ~ex_stall;

  // A JAL flagged together with a branch is handled as a JAL.
  always_comb begin
    cnt_next = bht_cnt[ex_idx];
    if (ex_is_jal) begin
      cnt_next = 2'b11;
    end else if (ex_br_en) begin
      cnt_next = sat_inc(bht_cnt[ex_idx]);
    end else begin
      cnt_next = sat_dec(bht_cnt[ex_idx]);
    end
  end

  // Control state: counters, valid bits and statistics are reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht_cnt[i] <= 2'b01;
      end
      btb_vld          <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (train) begin
      bht_cnt[ex_idx] <= cnt_next;
      if (taken) begin
        btb_vld[ex_idx] <= 1'b1;
      end
      branch_count <= branch_count + 32'd1;
      if (mispredict) begin
        mispredict_count <= mispredict_count + 32'd1;
      end
    end
  end

  // Tag and target payload; meaningless while the valid bit is clear.
  always_ff @(posedge clk) begin
    if (train && taken) begin
      btb_tag[ex_idx] <= ex_tag;
      btb_tgt[ex_idx] <= ex_target;
    end
  end

endmodule
